// File: rtl/allocate_pkg.sv
// allocate_pkg: shared types and default constants for the allocate_stream
// packet-allocation stage.
//   alloc_state_t : framing FSM state
//   alloc_entry_t : output buffer entry layout {first, last, index, word} at
//                   the default widths; the top builds the same layout at its
//                   own parameterised widths.
package allocate_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int CNT_W_DEF      = 6;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MAX_WORDS_DEF  = (2 ** CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2,
    S_FLUSH  = 2'd3
  } alloc_state_t;

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic [CNT_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] word;
  } alloc_entry_t;

endpackage

// File: rtl/alloc_fifo.sv
// alloc_fifo: synchronous FIFO with first-word fall-through.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/wdata : write an entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   rdata      : head entry, valid whenever empty is low
//   count      : number of stored entries, 0..DEPTH
//   empty      : no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
module alloc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/allocate_stream.sv
// allocate_stream: tags framed input words with their in-packet index,
// buffers them and presents them downstream with valid/ready.
//   clk, rst                 : clock, synchronous active-high reset
//   sop_in                   : arms the block for the next packet
//   new_word_r/first_word_r/
//   last_word_r/word_r       : input word strobe, framing flags and data
//   ready_r                  : buffer has room (not crediting a same-cycle pop)
//   new_word_a/ready_a       : output valid / downstream accept
//   first_word_a/last_word_a : framing flags of the head word
//   word_a                   : {index, word} of the head word
//   num_values_a             : index+1 of the head word
//   packet_in_progress       : packet open or words still queued
//   err_a                    : one-cycle pulse per edge with a framing violation
// All outputs are forced to 0 while rst is high.
module allocate_stream
  import allocate_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_WORDS  = (2 ** CNT_W) - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sop_in,
  input  logic                    new_word_r,
  input  logic                    first_word_r,
  input  logic                    last_word_r,
  input  logic [DATA_W-1:0]       word_r,
  output logic                    ready_r,
  output logic                    new_word_a,
  input  logic                    ready_a,
  output logic                    first_word_a,
  output logic                    last_word_a,
  output logic [DATA_W+CNT_W-1:0] word_a,
  output logic [CNT_W-1:0]        num_values_a,
  output logic                    packet_in_progress,
  output logic                    err_a
);

  localparam int ENTRY_W = DATA_W + CNT_W + 2;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WORDS - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

  alloc_state_t     state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, push_idx;
  logic             err_q, err_d;
  logic             push, push_first, push_last;
  logic             accept, pop, vld;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty;
  logic [ENTRY_W-1:0] wdata, rdata;

  assign ready_r = !rst && (fifo_cnt < FULL_CNT);
  assign accept  = new_word_r && ready_r;

  // Framing decode. The word is evaluated in the current state first; sop_in
  // is then applied on top of whatever the word did.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    push       = 1'b0;
    push_first = 1'b0;
    push_last  = 1'b0;
    push_idx   = '0;
    err_d      = new_word_r && !ready_r;  // word offered with no room
    if (accept) begin
      case (state_q)
        S_IDLE: err_d = 1'b1;
        S_ARMED: begin
          if (first_word_r) begin
            push       = 1'b1;
            push_first = 1'b1;
            push_last  = last_word_r;
            state_d    = last_word_r ? S_IDLE : S_ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
        S_ACTIVE: begin
          push      = 1'b1;
          push_last = last_word_r;
          if (first_word_r) begin
            // restart: new packet begins at this word
            push_first = 1'b1;
            err_d      = 1'b1;
          end else begin
            push_idx = idx_q + CNT_W'(1);
          end
          state_d = last_word_r ? S_IDLE : S_ACTIVE;
        end
        default: ;  // S_FLUSH: drop silently
      endcase
      if (push) begin
        idx_d = push_idx;
        // Packet hit the length limit without a last flag: close it here
        // and swallow the rest until the next sop_in.
        if (push_idx == LAST_IDX && !last_word_r) begin
          push_last = 1'b1;
          err_d     = 1'b1;
          state_d   = S_FLUSH;
        end
      end
    end
    if (sop_in) begin
      if (state_d == S_ACTIVE) err_d = 1'b1;  // open packet aborted
      state_d = S_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign wdata = {push_first, push_last, push_idx, word_r};

  alloc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // Head fields are masked when nothing is valid so stale storage never leaks.
  assign vld                = !rst && !fifo_empty;
  assign pop                = vld && ready_a;
  assign new_word_a         = vld;
  assign first_word_a       = vld && rdata[ENTRY_W-1];
  assign last_word_a        = vld && rdata[ENTRY_W-2];
  assign word_a             = vld ? rdata[DATA_W+CNT_W-1:0] : '0;
  assign num_values_a       = vld ? rdata[DATA_W +: CNT_W] + CNT_W'(1) : '0;
  assign packet_in_progress = !rst && ((state_q != S_IDLE) || !fifo_empty);
  assign err_a              = !rst && err_q;

endmodule

// File: tb/tb_allocate_stream.sv
module tb_allocate_stream;

  logic        clk = 1'b0;
  logic        rst, sop_in, new_word_r, first_word_r, last_word_r, ready_a;
  logic [31:0] word_r;
  logic        ready_r, new_word_a, first_word_a, last_word_a;
  logic        packet_in_progress, err_a;
  logic [37:0] word_a;
  logic [5:0]  num_values_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  allocate_stream #(
    .DATA_W(32), .CNT_W(6), .FIFO_DEPTH(4), .MAX_WORDS(4)
  ) dut (
    .clk(clk), .rst(rst), .sop_in(sop_in), .new_word_r(new_word_r),
    .first_word_r(first_word_r), .last_word_r(last_word_r), .word_r(word_r),
    .ready_r(ready_r), .new_word_a(new_word_a), .ready_a(ready_a),
    .first_word_a(first_word_a), .last_word_a(last_word_a), .word_a(word_a),
    .num_values_a(num_values_a), .packet_in_progress(packet_in_progress),
    .err_a(err_a)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sop();
    sop_in = 1'b1;
    step();
    sop_in = 1'b0;
  endtask

  task automatic send(input logic f, input logic l, input logic [31:0] d);
    new_word_r = 1'b1; first_word_r = f; last_word_r = l; word_r = d;
    step();
    new_word_r = 1'b0; first_word_r = 1'b0; last_word_r = 1'b0;
  endtask

  logic [37:0] pkt [4];

  initial begin
    pkt[0] = 38'h00F00CC05A; pkt[1] = 38'h017D000007;
    pkt[2] = 38'h0200000020; pkt[3] = 38'h03FE000000;
    rst = 1'b1; sop_in = 0; new_word_r = 0; first_word_r = 0; last_word_r = 0;
    word_r = '0; ready_a = 1'b1;
    step();
    // reset state
    chk("rst_ready_r", ready_r, 0);
    chk("rst_valid", new_word_a, 0);
    chk("rst_pip", packet_in_progress, 0);
    chk("rst_err", err_a, 0);
    chk("rst_word", word_a, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", ready_r, 1);

    // normal packet with idle cycles between words
    sop();
    chk("armed_pip", packet_in_progress, 1);
    send(1, 0, 32'hF00CC05A);
    chk("n0_valid", new_word_a, 1);
    chk("n0_word", word_a, pkt[0]);
    chk("n0_first", first_word_a, 1);
    chk("n0_num", num_values_a, 1);
    step();
    chk("n_gap_valid", new_word_a, 0);
    send(0, 0, 32'h7D000007);
    chk("n1_word", word_a, pkt[1]);
    chk("n1_first", first_word_a, 0);
    step();
    send(0, 0, 32'h00000020);
    chk("n2_word", word_a, pkt[2]);
    step();
    send(0, 1, 32'hFE000000);
    chk("n3_word", word_a, pkt[3]);
    chk("n3_last", last_word_a, 1);
    chk("n3_num", num_values_a, 4);
    chk("n3_pip", packet_in_progress, 1);
    chk("n_err", err_a, 0);
    step();
    chk("n_pip_fall", packet_in_progress, 0);

    // backpressure: back-to-back words, downstream stalled
    ready_a = 1'b0;
    sop();
    send(1, 0, 32'hF00CC05A);
    send(0, 0, 32'h7D000007);
    send(0, 0, 32'h00000020);
    chk("bp_ready_3", ready_r, 1);
    send(0, 1, 32'hFE000000);
    chk("bp_ready_4", ready_r, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_word", word_a, pkt[0]);
      chk("bp_hold_first", first_word_a, 1);
      step();
    end
    ready_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", new_word_a, 1);
      chk("bp_drain_word", word_a, pkt[i]);
      step();
    end
    chk("bp_empty", new_word_a, 0);
    chk("bp_pip", packet_in_progress, 0);

    // framing: word without sop
    send(1, 0, 32'h11111111);
    chk("nosop_err", err_a, 1);
    chk("nosop_drop", new_word_a, 0);
    step();
    chk("nosop_err_1cyc", err_a, 0);
    // framing: non-first word after sop
    sop();
    send(0, 0, 32'h22222222);
    chk("nofirst_err", err_a, 1);
    chk("nofirst_drop", new_word_a, 0);
    send(1, 1, 32'hAAAA5555);
    chk("nofirst_recover", word_a, 38'h00AAAA5555);
    chk("nofirst_fl", {first_word_a, last_word_a}, 2'b11);
    chk("nofirst_err_clr", err_a, 0);
    step();

    // overflow at MAX_WORDS = 4
    sop();
    send(1, 0, 32'hC0);
    send(0, 0, 32'hC1);
    send(0, 0, 32'hC2);
    send(0, 0, 32'hC3);
    chk("ovf_word", word_a, {6'd3, 32'hC3});
    chk("ovf_last", last_word_a, 1);
    chk("ovf_num", num_values_a, 4);
    chk("ovf_err", err_a, 1);
    send(0, 0, 32'hC4);
    chk("ovf_drop5", new_word_a, 0);
    chk("ovf_drop5_err", err_a, 0);
    send(0, 1, 32'hC5);
    chk("ovf_drop6", new_word_a, 0);
    chk("ovf_flush_pip", packet_in_progress, 1);
    sop();
    send(1, 1, 32'hD0);
    chk("ovf_next", word_a, {6'd0, 32'hD0});
    chk("ovf_next_err", err_a, 0);
    step();

    // restart via first_word_r mid-packet
    sop();
    send(1, 0, 32'hA0);
    send(0, 0, 32'hA1);
    chk("rs_idx1", word_a, {6'd1, 32'hA1});
    send(1, 0, 32'hA2);
    chk("rs_err", err_a, 1);
    chk("rs_word", word_a, {6'd0, 32'hA2});
    chk("rs_first", first_word_a, 1);
    send(0, 1, 32'hA3);
    chk("rs_err_clr", err_a, 0);
    chk("rs_after", word_a, {6'd1, 32'hA3});
    chk("rs_num", num_values_a, 2);
    step();

    // abort via sop_in mid-packet; queued words still drain
    ready_a = 1'b0;
    sop();
    send(1, 0, 32'hB0);
    send(0, 0, 32'hB1);
    sop();
    chk("ab_err", err_a, 1);
    send(1, 1, 32'hB2);
    chk("ab_err_clr", err_a, 0);
    ready_a = 1'b1;
    chk("ab_d0", word_a, {6'd0, 32'hB0});
    step();
    chk("ab_d1", word_a, {6'd1, 32'hB1});
    step();
    chk("ab_d2", word_a, {6'd0, 32'hB2});
    chk("ab_d2_fl", {first_word_a, last_word_a}, 2'b11);
    step();
    chk("ab_pip", packet_in_progress, 0);

    // reset with 3 queued words
    ready_a = 1'b0;
    sop();
    send(1, 0, 32'hE0);
    send(0, 0, 32'hE1);
    send(0, 0, 32'hE2);
    rst = 1'b1;
    step();
    chk("mr_valid", new_word_a, 0);
    chk("mr_word", word_a, 0);
    chk("mr_ready", ready_r, 0);
    chk("mr_pip", packet_in_progress, 0);
    chk("mr_flags", {first_word_a, last_word_a, err_a}, 0);
    rst = 1'b0;
    ready_a = 1'b1;
    step();
    chk("mr_no_stale", new_word_a, 0);
    chk("mr_ready_back", ready_r, 1);
    step();
    chk("mr_no_stale2", new_word_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/allocate_stream.md
# allocate_stream

Parametrised packet-allocation stage of the serializer datapath. It sits between the word reader and the packing stage. It accepts framed words from the reader (`sop_in`, first/last/new strobes) and tags each word with its position in the packet. Tagged words are buffered in a small FIFO and presented downstream with a valid/ready handshake. Framing violations are detected and reported, with defined recovery for each.

## Interface
- `DATA_W`, 32, width of an input word.
- `CNT_W`, 6, width of the in-packet index and count fields.
- `FIFO_DEPTH`, 4, number of output buffer entries; must be a power of two and at least 2.
- `MAX_WORDS`, 2**CNT_W-1, maximum packet length in words; must not exceed 2**CNT_W-1.

Ports:
- `clk` in 1, single clock; all logic is on the rising edge.
- `rst` in 1, synchronous, active-high reset.
- `sop_in` in 1, one-cycle pulse that arms the block for the next packet.
- `new_word_r` in 1, input word valid strobe.
- `first_word_r` in 1, marks the first word of a packet; qualified by `new_word_r`.
- `last_word_r` in 1, marks the last word of a packet; qualified by `new_word_r`.
- `word_r` in `DATA_W`, input word.
- `ready_r` out 1, upstream may assert `new_word_r`.
- `new_word_a` out 1, output word valid.
- `ready_a` in 1, downstream accepts the output word.
- `first_word_a` out 1, output word is the first of its packet.
- `last_word_a` out 1, output word is the last of its packet.
- `word_a` out `DATA_W+CNT_W`, output word, packed as `{index[CNT_W-1:0], word[DATA_W-1:0]}`.
- `num_values_a` out `CNT_W`, equals index+1 of the current output word; on the last word it is the packet length.
- `packet_in_progress` out 1, packet is open or still draining.
- `err_a` out 1, one-cycle pulse on any framing violation.

## Operation
- FSM states: IDLE, ARMED, ACTIVE, FLUSH.
- A word is **accepted** when `new_word_r` and `ready_r` are both high.
- IDLE:
  - `sop_in` moves the FSM to ARMED.
  - An accepted word is dropped and `err_a` pulses.
- ARMED:
  - An accepted word with `first_word_r` is pushed with index 0. The FSM goes to ACTIVE, or stays IDLE-bound (goes to IDLE) if `last_word_r` is also set, giving a 1-word packet.
  - An accepted word without `first_word_r` is dropped, `err_a` pulses, and the FSM stays in ARMED.
- ACTIVE: each accepted word is pushed with index = previous index + 1. Exceptions:
  - `last_word_r` pushes the word and moves the FSM to IDLE.
  - `first_word_r` restarts the packet: the word is pushed with index 0 and `first_word_a` set, and `err_a` pulses.
  - `sop_in` aborts the packet: `err_a` pulses and the FSM moves to ARMED. Words already queued still drain.
  - If the pushed index equals `MAX_WORDS-1` and `last_word_r` is 0, the word is pushed with the last flag forced to 1, `err_a` pulses, and the FSM moves to FLUSH.
- FLUSH: all accepted words are dropped without error. `sop_in` moves the FSM to ARMED.
- Simultaneous `sop_in` and an accepted word in ARMED, IDLE or FLUSH: the word is evaluated in the current state first, then `sop_in` applies.
- `ready_r` = (FIFO count < `FIFO_DEPTH`) and not `rst`. It does not credit a pop in the same cycle.
- If the upstream asserts `new_word_r` while `ready_r` is 0, the word is dropped and `err_a` pulses.
- `packet_in_progress` = (state ≠ IDLE) or (FIFO not empty).
- The FIFO stores `{first, last, index, word}`. Output fields come directly from the head entry (first-word fall-through).

## Timing
- Reset values:
  - Every output is 0 while `rst` is high; this includes `ready_r`.
  - FIFO is empty, the index register is 0, and the FSM is in IDLE.
  - From the first cycle after reset deasserts, `ready_r` = 1.
- Reset applied mid-packet discards all FIFO contents in the same edge.
- Latency: a word accepted at edge k shows `new_word_a` = 1 in the cycle after edge k when the FIFO was empty.
- Output hold: while `new_word_a` = 1 and `ready_a` = 0, all `_a` outputs hold stable. The entry pops at an edge where both are 1.
- Push and pop at the same edge leave the count unchanged. Pushing when full is impossible because `ready_r` gates acceptance.
- `err_a` is registered and asserted for exactly one cycle after the offending edge. Several violations at the same edge produce a single pulse.
- Index and count arithmetic is `CNT_W` bits wide and never wraps, because `MAX_WORDS` bounds it.

## Structure
- `allocate_pkg` holds:
  - the state enum `alloc_state_t`;
  - the FIFO entry struct `alloc_entry_t`, parametrised through localparams of the defaults;
  - the default parameter constants.
- Sub-module `alloc_fifo`: a synchronous FIFO with `DEPTH` and `WIDTH` parameters, a count output, and first-word fall-through. `allocate_stream` instantiates it once.
- FSM, index counter and error logic live in the top module.

## Test plan
- **Normal packet, no backpressure:** `sop_in`, then 4 words `F00CC05A`(first), `7D000007`, `00000020`, `FE000000`(last) with idle cycles between them, `ready_a` = 1.
  - `word_a` = `38'h00F00CC05A`, `0x017D000007`, `0x0200000020`, `0x03FE000000`.
  - `num_values_a` on the last word = 4; `first_word_a` and `last_word_a` set on the correct words.
  - `packet_in_progress` falls the cycle after the last pop.
- **Backpressure:** same packet, back-to-back words, `ready_a` = 0 for 8 cycles.
  - `ready_r` falls after 4 pushes.
  - Outputs hold `0x00F00CC05A`.
  - On release, all 4 words emerge in order with no loss.
- **Framing errors:**
  - A word with no preceding `sop_in` is dropped with one `err_a` pulse.
  - After `sop_in`, a non-first word is dropped with one `err_a` pulse, and the following first word is accepted with index 0.
- **Overflow:** with `MAX_WORDS` = 4, a 6-word packet.
  - The 4th word exits with `last_word_a` = 1 and `num_values_a` = 4, and `err_a` pulses.
  - Words 5 and 6 are dropped.
  - The next `sop_in` packet is accepted normally.
- **Restart:** `first_word_r` mid-packet, and separately `sop_in` mid-packet.
  - Each gives one `err_a` pulse.
  - On `first_word_r` mid-packet, the index restarts at 0.
  - On `sop_in` mid-packet, queued words still drain.
- **Reset mid-packet** with 3 queued words: all outputs are 0 the next cycle, and no stale word appears after reset deasserts.
